param_counter: RTL and testbench

PARAM_COUNTER -- requirements
Module: param_counter

---
 rtl/param_counter_pkg.sv | 11 +
 rtl/param_counter_step.sv | 59 +++++
 rtl/param_counter.sv | 73 +++++++
 tb/tb_param_counter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_counter_pkg.sv
// Shared definitions for the parameterised up/down counter: mode encodings.
package param_counter_pkg;

    typedef enum logic [1:0] {
        MODE_FREE    = 2'b00,
        MODE_MOD     = 2'b01,
        MODE_SAT     = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_t;

endpackage

// File: rtl/param_counter_step.sv
// Combinational next-state logic: terminal detection, next count, wrap and done.
module param_counter_step
    import param_counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] q_next,
    output logic             tc,
    output logic             wrap_next,
    output logic             done_next
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    mode_t            mode_e;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] q_step;
    logic             step_term;

    assign mode_e    = mode_t'(mode);
    assign top       = (mode_e == MODE_FREE) ? {WIDTH{1'b1}} : limit;
    assign tc        = up ? (q == top) : (q == '0);
    assign q_step    = up ? (q + ONE) : (q - ONE);
    // One-shot completes on the edge that lands on the terminal value.
    assign step_term = up ? (q_step == top) : (q_step == '0);

    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        done_next = 1'b0;
        case (mode_e)
            MODE_FREE: begin
                q_next    = q_step;
                wrap_next = tc;
            end
            MODE_MOD: begin
                q_next    = tc ? (up ? '0 : limit) : q_step;
                wrap_next = tc;
            end
            MODE_SAT: begin
                if (!tc) q_next = q_step;
            end
            MODE_ONESHOT: begin
                if (tc) begin
                    done_next = 1'b1;
                end else begin
                    q_next    = q_step;
                    done_next = step_term;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/param_counter.sv
// Loadable up/down counter with free/modulo/saturate/one-shot modes and cascade carry.
module param_counter #(
    parameter int WIDTH = 8
) (
    input  logic             CP,
    input  logic             CRn,
    input  logic             SCLRn,
    input  logic             LDn,
    input  logic [WIDTH-1:0] D,
    input  logic             CTT,
    input  logic             CTP,
    input  logic             UP,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] LIMIT,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             CO,
    output logic             WRAP,
    output logic             DONE
);

    logic [WIDTH-1:0] q_r;
    logic             wrap_r;
    logic             done_r;
    logic [WIDTH-1:0] q_next;
    logic             tc;
    logic             wrap_next;
    logic             done_next;
    logic             count_en;

    param_counter_step #(.WIDTH(WIDTH)) u_step (
        .q         (q_r),
        .up        (UP),
        .mode      (MODE),
        .limit     (LIMIT),
        .q_next    (q_next),
        .tc        (tc),
        .wrap_next (wrap_next),
        .done_next (done_next)
    );

    // A completed one-shot freezes the count until cleared or reloaded.
    assign count_en = CTT & CTP & ~done_r;

    always_ff @(posedge CP or negedge CRn) begin
        if (!CRn) begin
            q_r    <= '0;
            wrap_r <= 1'b0;
            done_r <= 1'b0;
        end else if (!SCLRn) begin
            q_r    <= '0;
            wrap_r <= 1'b0;
            done_r <= 1'b0;
        end else if (!LDn) begin
            q_r    <= D;
            wrap_r <= 1'b0;
            done_r <= 1'b0;
        end else if (count_en) begin
            q_r    <= q_next;
            wrap_r <= wrap_next;
            done_r <= done_next;
        end else begin
            wrap_r <= 1'b0;
        end
    end

    assign Q    = q_r;
    assign TC   = tc;
    assign CO   = CTT & tc;
    assign WRAP = wrap_r;
    assign DONE = done_r;

endmodule

// File: tb/tb_param_counter.sv
// Randomised and directed checks of param_counter (WIDTH=4) against a behavioural model.
module tb_param_counter;

    logic       CP = 1'b0;
    logic       CRn = 1'b1;
    logic       SCLRn = 1'b1;
    logic       LDn = 1'b1;
    logic [3:0] D = 4'd0;
    logic       CTT = 1'b0;
    logic       CTP = 1'b0;
    logic       UP = 1'b0;
    logic [1:0] MODE = 2'b00;
    logic [3:0] LIMIT = 4'd0;
    logic [3:0] Q;
    logic       TC, CO, WRAP, DONE;

    // cascade pair
    logic       c_ldn = 1'b1;
    logic [3:0] c_d_lo = 4'd0, c_d_hi = 4'd0;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, lo_co, lo_wrap, lo_done;
    logic       hi_tc, hi_co, hi_wrap, hi_done;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    int m_q = 0, m_wrap = 0, m_done = 0;

    always #5 CP = ~CP;

    param_counter #(.WIDTH(4)) u_dut (
        .CP(CP), .CRn(CRn), .SCLRn(SCLRn), .LDn(LDn), .D(D), .CTT(CTT), .CTP(CTP),
        .UP(UP), .MODE(MODE), .LIMIT(LIMIT), .Q(Q), .TC(TC), .CO(CO), .WRAP(WRAP), .DONE(DONE)
    );

    param_counter #(.WIDTH(4)) u_lo (
        .CP(CP), .CRn(CRn), .SCLRn(1'b1), .LDn(c_ldn), .D(c_d_lo), .CTT(1'b1), .CTP(1'b1),
        .UP(1'b1), .MODE(2'b00), .LIMIT(4'd0), .Q(lo_q), .TC(lo_tc), .CO(lo_co),
        .WRAP(lo_wrap), .DONE(lo_done)
    );

    param_counter #(.WIDTH(4)) u_hi (
        .CP(CP), .CRn(CRn), .SCLRn(1'b1), .LDn(c_ldn), .D(c_d_hi), .CTT(lo_co), .CTP(1'b1),
        .UP(1'b1), .MODE(2'b00), .LIMIT(4'd0), .Q(hi_q), .TC(hi_tc), .CO(hi_co),
        .WRAP(hi_wrap), .DONE(hi_done)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int top_of(input int mode, input int limit);
        return (mode == 0) ? 15 : limit;
    endfunction

    function automatic int term_of(input int q, input int up, input int mode, input int limit);
        return up ? (q == top_of(mode, limit)) : (q == 0);
    endfunction

    // Behavioural reference: what the counter must hold after each edge.
    always @(posedge CP or negedge CRn) begin
        int top, at_term, nxt;
        if (!CRn) begin
            m_q = 0; m_wrap = 0; m_done = 0;
        end else if (!SCLRn) begin
            m_q = 0; m_wrap = 0; m_done = 0;
        end else if (!LDn) begin
            m_q = int'(D); m_wrap = 0; m_done = 0;
        end else if (CTT && CTP && m_done == 0) begin
            top     = top_of(int'(MODE), int'(LIMIT));
            at_term = term_of(m_q, int'(UP), int'(MODE), int'(LIMIT));
            nxt     = UP ? (m_q + 1) % 16 : (m_q + 15) % 16;
            m_wrap  = 0;
            case (int'(MODE))
                0: begin m_wrap = at_term; m_q = nxt; end
                1: begin m_wrap = at_term; m_q = at_term ? (UP ? 0 : top) : nxt; end
                2: if (at_term == 0) m_q = nxt;
                default: begin
                    if (at_term != 0) m_done = 1;
                    else begin
                        m_q = nxt;
                        m_done = UP ? (nxt == top) : (nxt == 0);
                    end
                end
            endcase
        end else begin
            m_wrap = 0;
        end
    end

    always @(negedge CP) begin
        int e_tc;
        if (chk_en) begin
            e_tc = term_of(m_q, int'(UP), int'(MODE), int'(LIMIT));
            chk("model_q",    int'(Q),    m_q);
            chk("model_tc",   int'(TC),   e_tc);
            chk("model_co",   int'(CO),   e_tc & int'(CTT));
            chk("model_wrap", int'(WRAP), m_wrap);
            chk("model_done", int'(DONE), m_done);
        end
    end

    task automatic edge_();
        @(negedge CP);
        #1;
    endtask

    task automatic setm(input logic ctt, input logic ctp, input logic up,
                        input logic [1:0] mode, input logic [3:0] limit);
        CTT = ctt; CTP = ctp; UP = up; MODE = mode; LIMIT = limit;
    endtask

    task automatic load(input logic [3:0] v);
        LDn = 1'b0; D = v;
        edge_();
        LDn = 1'b1;
    endtask

    initial begin
        int wraps;
        #1 CRn = 1'b0;
        #3 CRn = 1'b1;
        chk_en = 1'b1;
        edge_();

        // after reset, Q=0
        setm(1, 0, 0, 2'b00, 4'd0); #1;
        chk("rst_q", int'(Q), 0);
        chk("rst_tc_down", int'(TC), 1);
        chk("rst_co_down", int'(CO), 1);
        setm(1, 0, 1, 2'b01, 4'd0); #1;
        chk("rst_tc_up_lim0", int'(TC), 1);
        setm(1, 0, 1, 2'b00, 4'd0); #1;
        chk("rst_tc_up_free", int'(TC), 0);
        edge_();

        // free-running up through wrap
        load(4'hE);
        setm(1, 1, 1, 2'b00, 4'd0);
        edge_();
        chk("free_q_f", int'(Q), 15);
        chk("free_tc_f", int'(TC), 1);
        chk("free_co_f", int'(CO), 1);
        edge_();
        chk("free_q_0", int'(Q), 0);
        chk("free_wrap", int'(WRAP), 1);
        edge_();
        chk("free_q_1", int'(Q), 1);
        chk("free_wrap_clr", int'(WRAP), 0);

        // modulo-10
        setm(0, 1, 1, 2'b01, 4'd9);
        load(4'd0);
        CTT = 1'b1;
        wraps = 0;
        for (int i = 0; i < 10; i++) begin
            edge_();
            wraps += int'(WRAP);
        end
        chk("mod_q", int'(Q), 0);
        chk("mod_wraps", wraps, 1);
        UP = 1'b0;
        edge_();
        chk("mod_down_q", int'(Q), 9);
        chk("mod_down_wrap", int'(WRAP), 1);

        // saturate
        setm(0, 1, 1, 2'b10, 4'd5);
        load(4'd4);
        CTT = 1'b1;
        wraps = 0;
        for (int i = 0; i < 3; i++) begin
            edge_();
            chk("sat_up_q", int'(Q), 5);
            wraps += int'(WRAP);
        end
        chk("sat_no_wrap", wraps, 0);
        UP = 1'b0;
        repeat (6) edge_();
        chk("sat_down_q", int'(Q), 0);
        chk("sat_down_wrap", int'(WRAP), 0);

        // one-shot
        setm(0, 1, 1, 2'b11, 4'd3);
        load(4'd1);
        CTT = 1'b1;
        edge_();
        chk("os_q2", int'(Q), 2);
        chk("os_done0", int'(DONE), 0);
        edge_();
        chk("os_q3", int'(Q), 3);
        chk("os_done1", int'(DONE), 1);
        repeat (2) edge_();
        chk("os_hold", int'(Q), 3);
        load(4'd0);
        chk("os_reload_q", int'(Q), 0);
        chk("os_reload_done", int'(DONE), 0);

        // clear beats load beats count
        setm(1, 1, 1, 2'b00, 4'd0);
        load(4'd3);
        SCLRn = 1'b0; LDn = 1'b0; D = 4'd7;
        edge_();
        SCLRn = 1'b1; LDn = 1'b1;
        chk("prio_q", int'(Q), 0);

        // async reset mid-count with WRAP high
        setm(1, 1, 0, 2'b01, 4'd6);
        load(4'd0);
        edge_();
        chk("arst_pre_q", int'(Q), 6);
        chk("arst_pre_wrap", int'(WRAP), 1);
        CRn = 1'b0;
        #1;
        chk("arst_q", int'(Q), 0);
        chk("arst_wrap", int'(WRAP), 0);
        #1 CRn = 1'b1;
        edge_();
        chk("arst_first_count", int'(Q), 6);

        // cascade
        c_ldn = 1'b0; c_d_lo = 4'hF; c_d_hi = 4'hF;
        edge_();
        c_ldn = 1'b1;
        #0;
        chk("casc_pre", int'({hi_q, lo_q}), 8'hFF);
        chk("casc_lo_co", int'(lo_co), 1);
        edge_();
        chk("casc_wrap", int'({hi_q, lo_q}), 0);
        chk("casc_hi_wrap", int'(hi_wrap), 1);
        c_ldn = 1'b0; c_d_lo = 4'h3; c_d_hi = 4'h2;
        edge_();
        c_ldn = 1'b1;
        edge_();
        chk("casc_inc", int'({hi_q, lo_q}), 8'h24);

        // randomised phase
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(63) == 0) begin
                CRn = 1'b0;
                #1 CRn = 1'b1;
            end
            SCLRn = ($urandom_range(19) != 0);
            LDn   = ($urandom_range(11) != 0);
            D     = 4'($urandom_range(15));
            CTT   = ($urandom_range(7) != 0);
            CTP   = ($urandom_range(7) != 0);
            if ($urandom_range(15) == 0) UP = ~UP;
            if ($urandom_range(31) == 0) MODE = 2'($urandom_range(3));
            if ($urandom_range(31) == 0)
                LIMIT = ($urandom_range(3) == 0) ? 4'd0 : 4'($urandom_range(15));
            edge_();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
